paddle_ctl: RTL and testbench

Upstream paddle front end for the pong game core. Turns one player's raw controls into the registered paddle centre coordinate that the game core consumes as `paddleA_y` / `paddleB_y`; one instance per player. Controls are a quadrature rotary encoder plus up/down push-buttons with auto-repeat. Movement is accumulated during the frame and applied once per frame on the vsync edge, so the paddle never tears mid-scan.

---
 rtl/paddle_ctl_if.sv | 22 ++
 rtl/paddle_ctl.sv | 188 ++++++++++++++++++
 tb/tb_paddle_ctl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/paddle_ctl_if.sv
// rtl/paddle_ctl_if.sv - player control and paddle position bundle for paddle_ctl
interface paddle_ctl_if;
    logic       enc_a;
    logic       enc_b;
    logic       btn_up;
    logic       btn_dn;
    logic       vsync;
    logic       center;
    logic [9:0] paddle_y;
    logic       moved;
    logic       enc_err;

    modport master (
        output enc_a, enc_b, btn_up, btn_dn, vsync, center,
        input  paddle_y, moved, enc_err
    );

    modport slave (
        input  enc_a, enc_b, btn_up, btn_dn, vsync, center,
        output paddle_y, moved, enc_err
    );
endinterface

// File: rtl/paddle_ctl.sv
// rtl/paddle_ctl.sv - encoder/button paddle front end with once-per-frame position update
module paddle_ctl #(
    parameter logic [9:0] SCREENHEIGHT = 10'd480,
    parameter logic [9:0] PADDLESIZE   = 10'd64,
    parameter int         FILTER       = 4,
    parameter int         STEP         = 2,
    parameter int         FASTHOLD     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    paddle_ctl_if.slave bus
);

    localparam logic [3:0]         FILT_LAST = 4'(FILTER - 1);
    localparam logic signed [9:0]  ENC_STEP  = 10'(STEP);
    localparam logic signed [11:0] BTN_SLOW  = 12'(STEP);
    localparam logic signed [11:0] BTN_FAST  = 12'(2 * STEP);
    localparam logic [7:0]         FAST_N    = 8'(FASTHOLD);
    localparam logic [9:0]         Y_CENTER  = SCREENHEIGHT >> 1;
    localparam logic [9:0]         Y_MIN     = PADDLESIZE >> 1;
    localparam logic [9:0]         Y_MAX     = SCREENHEIGHT - 10'd1 - (PADDLESIZE >> 1);

    // Bit order of the conditioned inputs: 0 enc_a, 1 enc_b, 2 btn_up, 3 btn_dn, 4 vsync
    logic [4:0]       raw;
    logic [4:0]       sync1;
    logic [4:0]       sync2;
    logic [4:0]       filt;
    logic [4:0][3:0]  gcnt;

    logic [1:0]       ab;
    logic [1:0]       ab_prev;
    logic [1:0]       idx_now;
    logic [1:0]       idx_prev;
    logic [1:0]       idx_diff;
    logic             cnt_fwd;
    logic             cnt_rev;
    logic             illegal;
    logic             vs_prev;
    logic             vs_rise;

    logic signed [8:0]  pending;
    logic signed [9:0]  enc_delta;
    logic [7:0]         hold_cnt;
    logic               hold_dir;
    logic [7:0]         hold_next;
    logic               btn_one_up;
    logic               btn_one_dn;
    logic               btn_held;
    logic signed [11:0] btn_term;
    logic signed [11:0] target;
    logic [9:0]         y_applied;
    logic [9:0]         y_next;

    logic [9:0]         paddle_y;
    logic               moved;
    logic               enc_err;

    assign raw = {bus.vsync, bus.btn_dn, bus.btn_up, bus.enc_b, bus.enc_a};

    assign bus.paddle_y = paddle_y;
    assign bus.moved    = moved;
    assign bus.enc_err  = enc_err;

    // Two-flop synchroniser for every asynchronous control input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Glitch filter: accept a new level only after FILTER consecutive differing cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= '0;
            gcnt <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == filt[i]) begin
                    gcnt[i] <= 4'd0;
                end else if (gcnt[i] == FILT_LAST) begin
                    filt[i] <= sync2[i];
                    gcnt[i] <= 4'd0;
                end else begin
                    gcnt[i] <= gcnt[i] + 4'd1;
                end
            end
        end
    end

    // Quadrature phase index: 00->0, 01->1, 11->2, 10->3, so forward motion is +1 mod 4
    assign ab       = {filt[0], filt[1]};
    assign idx_now  = {ab[1], ab[1] ^ ab[0]};
    assign idx_prev = {ab_prev[1], ab_prev[1] ^ ab_prev[0]};
    assign idx_diff = idx_now - idx_prev;
    assign cnt_fwd  = (idx_diff == 2'd1);
    assign cnt_rev  = (idx_diff == 2'd3);
    assign illegal  = (idx_diff == 2'd2);
    assign vs_rise  = filt[4] & ~vs_prev;

    assign enc_delta = cnt_fwd ? ENC_STEP : (cnt_rev ? -ENC_STEP : 10'sd0);

    // Previous filtered levels for encoder step and vsync edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ab_prev <= 2'b00;
            vs_prev <= 1'b0;
        end else begin
            ab_prev <= ab;
            vs_prev <= filt[4];
        end
    end

    function automatic logic signed [8:0] sat_add(input logic signed [8:0] p,
                                                  input logic signed [9:0] d);
        logic signed [9:0] s;
        s = $signed({p[8], p}) + d;
        if (s > 10'sd255)
            return 9'sd255;
        else if (s < $signed(10'h300))
            return $signed(9'h100);
        else
            return s[8:0];
    endfunction

    // Button repeat term and clamped frame target
    always_comb begin
        btn_one_up = filt[2] & ~filt[3];
        btn_one_dn = filt[3] & ~filt[2];
        btn_held   = btn_one_up | btn_one_dn;
        hold_next  = 8'd0;
        btn_term   = 12'sd0;
        if (btn_held) begin
            if (hold_cnt != 8'd0 && hold_dir == btn_one_dn)
                hold_next = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
            else
                hold_next = 8'd1;
            if (hold_next > FAST_N)
                btn_term = btn_one_dn ? BTN_FAST : -BTN_FAST;
            else
                btn_term = btn_one_dn ? BTN_SLOW : -BTN_SLOW;
        end
        target = $signed({2'b00, paddle_y}) + $signed({{3{pending[8]}}, pending}) + btn_term;
        if (target < $signed({2'b00, Y_MIN}))
            y_applied = Y_MIN;
        else if (target > $signed({2'b00, Y_MAX}))
            y_applied = Y_MAX;
        else
            y_applied = target[9:0];
        if (bus.center)
            y_next = Y_CENTER;
        else if (vs_rise)
            y_next = y_applied;
        else
            y_next = paddle_y;
    end

    // Pending delta, hold tracking, paddle position and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= 9'sd0;
            hold_cnt <= 8'd0;
            hold_dir <= 1'b0;
            paddle_y <= Y_CENTER;
            moved    <= 1'b0;
            enc_err  <= 1'b0;
        end else begin
            if (bus.center) begin
                pending  <= 9'sd0;
                hold_cnt <= 8'd0;
                hold_dir <= 1'b0;
            end else if (vs_rise) begin
                pending  <= sat_add(9'sd0, enc_delta);
                hold_cnt <= hold_next;
                hold_dir <= btn_one_dn;
            end else begin
                pending  <= sat_add(pending, enc_delta);
            end
            paddle_y <= y_next;
            moved    <= (y_next != paddle_y);
            enc_err  <= enc_err | illegal;
        end
    end

endmodule

// File: tb/tb_paddle_ctl.sv
// tb/tb_paddle_ctl.sv - directed self-checking bench for paddle_ctl
module tb_paddle_ctl;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   mcount;
    int   m0;
    int   pos;
    int   exp_y;
    logic [1:0] order [4];

    paddle_ctl_if bus ();

    paddle_ctl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.moved === 1'b1)
            mcount = mcount + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_enc(input logic [1:0] abv, input int hold);
        bus.enc_a = abv[1];
        bus.enc_b = abv[0];
        tick(hold);
    endtask

    task automatic frame();
        bus.vsync = 1'b1;
        tick(12);
        bus.vsync = 1'b0;
        tick(12);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus.enc_a  = 1'b0;
        bus.enc_b  = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        bus.vsync  = 1'b0;
        bus.center = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        total++; if (bus.paddle_y !== 10'd240) begin bad++; $display("FAIL reset_y got=%0d exp=240", bus.paddle_y); end
        total++; if (bus.moved !== 1'b0) begin bad++; $display("FAIL reset_moved got=%b exp=0", bus.moved); end
        total++; if (bus.enc_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.enc_err); end
        m0 = mcount;
        repeat (3) frame();
        total++; if (bus.paddle_y !== 10'd240) begin bad++; $display("FAIL idle_y got=%0d exp=240", bus.paddle_y); end
        total++; if (mcount - m0 !== 0) begin bad++; $display("FAIL idle_moved got=%0d exp=0", mcount - m0); end
        total++; if (bus.enc_err !== 1'b0) begin bad++; $display("FAIL idle_err got=%b exp=0", bus.enc_err); end
    endtask

    task automatic test_encoder_fwd();
        set_enc(2'b01, 8);
        set_enc(2'b11, 8);
        set_enc(2'b10, 8);
        set_enc(2'b00, 8);
        set_enc(2'b01, 8);
        m0 = mcount;
        bus.vsync = 1'b1;
        tick(6);
        total++; if (bus.paddle_y !== 10'd240) begin bad++; $display("FAIL fwd_early got=%0d exp=240", bus.paddle_y); end
        tick(1);
        total++; if (bus.paddle_y !== 10'd250) begin bad++; $display("FAIL fwd_y got=%0d exp=250", bus.paddle_y); end
        total++; if (bus.moved !== 1'b1) begin bad++; $display("FAIL fwd_moved got=%b exp=1", bus.moved); end
        tick(1);
        total++; if (bus.moved !== 1'b0) begin bad++; $display("FAIL fwd_moved_end got=%b exp=0", bus.moved); end
        tick(10);
        bus.vsync = 1'b0;
        tick(12);
        total++; if (mcount - m0 !== 1) begin bad++; $display("FAIL fwd_pulses got=%0d exp=1", mcount - m0); end
        total++; if (bus.paddle_y !== 10'd250) begin bad++; $display("FAIL fwd_hold got=%0d exp=250", bus.paddle_y); end
    endtask

    task automatic test_glitch();
        m0 = mcount;
        bus.enc_a = 1'b1; tick(1); bus.enc_a = 1'b0; tick(10);
        bus.enc_a = 1'b1; tick(3); bus.enc_a = 1'b0; tick(10);
        frame();
        total++; if (bus.paddle_y !== 10'd250) begin bad++; $display("FAIL glitch_y got=%0d exp=250", bus.paddle_y); end
        total++; if (mcount - m0 !== 0) begin bad++; $display("FAIL glitch_moved got=%0d exp=0", mcount - m0); end
        set_enc(2'b11, 8);
        frame();
        total++; if (bus.paddle_y !== 10'd252) begin bad++; $display("FAIL stable_y got=%0d exp=252", bus.paddle_y); end
        total++; if (mcount - m0 !== 1) begin bad++; $display("FAIL stable_moved got=%0d exp=1", mcount - m0); end
    endtask

    task automatic test_buttons();
        bus.center = 1'b1;
        tick(1);
        bus.center = 1'b0;
        total++; if (bus.paddle_y !== 10'd240) begin bad++; $display("FAIL center_y got=%0d exp=240", bus.paddle_y); end
        total++; if (bus.moved !== 1'b1) begin bad++; $display("FAIL center_moved got=%b exp=1", bus.moved); end
        bus.btn_up = 1'b1;
        tick(8);
        exp_y = 240;
        for (int f = 1; f <= 10; f++) begin
            exp_y = exp_y - ((f <= 8) ? 2 : 4);
            frame();
            total++;
            if (bus.paddle_y !== 10'(exp_y)) begin
                bad++;
                $display("FAIL hold_frame%0d got=%0d exp=%0d", f, bus.paddle_y, exp_y);
            end
        end
        bus.btn_dn = 1'b1;
        tick(8);
        m0 = mcount;
        frame();
        frame();
        total++; if (bus.paddle_y !== 10'd216) begin bad++; $display("FAIL both_y got=%0d exp=216", bus.paddle_y); end
        total++; if (mcount - m0 !== 0) begin bad++; $display("FAIL both_moved got=%0d exp=0", mcount - m0); end
        bus.btn_up = 1'b0;
        tick(8);
        frame();
        total++; if (bus.paddle_y !== 10'd218) begin bad++; $display("FAIL dn_y got=%0d exp=218", bus.paddle_y); end
        bus.btn_dn = 1'b0;
        tick(8);
    endtask

    task automatic test_clamp();
        pos = 2;
        for (int i = 0; i < 150; i++) begin
            pos = (pos + 3) % 4;
            set_enc(order[pos], 6);
        end
        m0 = mcount;
        frame();
        total++; if (bus.paddle_y !== 10'd32) begin bad++; $display("FAIL clamp_y got=%0d exp=32", bus.paddle_y); end
        total++; if (mcount - m0 !== 1) begin bad++; $display("FAIL clamp_moved got=%0d exp=1", mcount - m0); end
        bus.btn_up = 1'b1;
        tick(8);
        m0 = mcount;
        frame();
        total++; if (bus.paddle_y !== 10'd32) begin bad++; $display("FAIL clamp_up_y got=%0d exp=32", bus.paddle_y); end
        total++; if (mcount - m0 !== 0) begin bad++; $display("FAIL clamp_up_moved got=%0d exp=0", mcount - m0); end
        bus.btn_up = 1'b0;
        tick(8);
    endtask

    task automatic test_err_center();
        pos = (pos + 2) % 4;
        set_enc(order[pos], 8);
        total++; if (bus.enc_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", bus.enc_err); end
        m0 = mcount;
        frame();
        total++; if (bus.paddle_y !== 10'd32) begin bad++; $display("FAIL err_nocount got=%0d exp=32", bus.paddle_y); end
        total++; if (mcount - m0 !== 0) begin bad++; $display("FAIL err_moved got=%0d exp=0", mcount - m0); end
        for (int i = 0; i < 10; i++) begin
            pos = (pos + 1) % 4;
            set_enc(order[pos], 8);
        end
        bus.vsync = 1'b1;
        tick(6);
        bus.center = 1'b1;
        tick(1);
        bus.center = 1'b0;
        total++; if (bus.paddle_y !== 10'd240) begin bad++; $display("FAIL ctr_apply_y got=%0d exp=240", bus.paddle_y); end
        total++; if (bus.moved !== 1'b1) begin bad++; $display("FAIL ctr_apply_moved got=%b exp=1", bus.moved); end
        tick(11);
        bus.vsync = 1'b0;
        tick(12);
        m0 = mcount;
        frame();
        total++; if (bus.paddle_y !== 10'd240) begin bad++; $display("FAIL ctr_discard got=%0d exp=240", bus.paddle_y); end
        total++; if (mcount - m0 !== 0) begin bad++; $display("FAIL ctr_discard_moved got=%0d exp=0", mcount - m0); end
        total++; if (bus.enc_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", bus.enc_err); end
    endtask

    task automatic test_reset_mid();
        pos = (pos + 1) % 4;
        set_enc(order[pos], 8);
        frame();
        total++; if (bus.paddle_y !== 10'd242) begin bad++; $display("FAIL pre_reset_y got=%0d exp=242", bus.paddle_y); end
        pos = (pos + 1) % 4;
        set_enc(order[pos], 8);
        pos = (pos + 1) % 4;
        set_enc(order[pos], 8);
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (bus.paddle_y !== 10'd240) begin bad++; $display("FAIL async_reset_y got=%0d exp=240", bus.paddle_y); end
        total++; if (bus.enc_err !== 1'b0) begin bad++; $display("FAIL async_reset_err got=%b exp=0", bus.enc_err); end
        set_enc(2'b00, 4);
        reset_n = 1'b1;
        tick(10);
        frame();
        total++; if (bus.paddle_y !== 10'd240) begin bad++; $display("FAIL post_reset_y got=%0d exp=240", bus.paddle_y); end
        total++; if (bus.enc_err !== 1'b0) begin bad++; $display("FAIL post_reset_err got=%b exp=0", bus.enc_err); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        mcount   = 0;
        order[0] = 2'b00;
        order[1] = 2'b01;
        order[2] = 2'b11;
        order[3] = 2'b10;
        test_reset();
        test_encoder_fwd();
        test_glitch();
        test_buttons();
        test_clamp();
        test_err_center();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
